// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family.
//   GRAY_DEFAULT_WIDTH : default counter width in bits
//   bin2gray(b)        : reflected binary Gray encoding, b ^ (b >> 1)
//   gray2bin(g)        : Gray decoding via prefix XOR from the MSB down
// Both functions work on 64-bit zero-extended values; callers truncate to their width.
package gray_pkg;

    localparam int unsigned GRAY_DEFAULT_WIDTH = 32;

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter32_encode.sv
// gray_encode: combinational WIDTH-bit binary to reflected-binary Gray converter.
//   i_bin  : binary input
//   o_gray : Gray-coded output, i_bin ^ (i_bin >> 1)
module gray_encode #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter32.sv
// gray_counter32: free-running synchronous Gray-code counter.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset, clears the count to zero
//   q     : registered Gray-coded count; exactly one bit toggles per counting edge
// A binary register carries the count; the Gray output is encoded from the next binary
// value and registered on the same edge, so q never sees a combinational input path.
module gray_counter32
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;

    // Modulo-2^WIDTH increment; the carry out of the MSB is dropped on wrap.
    assign w_bin_next = r_bin + WIDTH'(1);

    gray_encode #(
        .WIDTH (WIDTH)
    ) u_encode (
        .i_bin  (w_bin_next),
        .o_gray (w_gray_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bin <= '0;
            r_q   <= '0;
        end else begin
            r_bin <= w_bin_next;
            r_q   <= w_gray_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_gray_counter32.sv
// Randomized self-checking bench for gray_counter32 (WIDTH=32 and WIDTH=4 instances).
module tb_gray_counter32;

    logic        clk;
    logic        reset;
    logic        reset4;
    logic [31:0] q;
    logic [3:0]  q4;

    gray_counter32 dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    gray_counter32 #(
        .WIDTH (4)
    ) dut4 (
        .clk   (clk),
        .reset (reset4),
        .q     (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model: count of counting edges since the last reset edge.
    logic [31:0] k32;
    logic [3:0]  k4;
    logic        prev_ok;
    logic        prev4_ok;
    logic [31:0] q_prev;
    logic [3:0]  q4_prev;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Gray code of v over w bits: bit i flips whenever bit i and bit i+1 of v differ.
    function automatic logic [63:0] ref_gray(input logic [63:0] v, input int w);
        logic [63:0] g;
        g = '0;
        for (int i = 0; i < w; i++) begin
            if (i + 1 < w) g[i] = v[i] ^ v[i+1];
            else           g[i] = v[i];
        end
        return g;
    endfunction

    function automatic logic [63:0] ref_decode(input logic [63:0] g, input int w);
        logic [63:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = w - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    task automatic tick(input logic rst_main, input logic rst_small);
        reset  = rst_main;
        reset4 = rst_small;
        q_prev  = q;
        q4_prev = q4;
        @(posedge clk);
        if (!rst_main) k32 = '0; else k32 = k32 + 32'd1;
        if (!rst_small) k4 = '0; else k4 = k4 + 4'd1;
        #1;
    endtask

    task automatic check_main(input string tag, input logic counted);
        check_eq({tag, "_q"}, 64'(q), ref_gray(64'(k32), 32));
        check_eq({tag, "_dec"}, ref_decode(64'(q), 32), 64'(k32));
        if (counted && prev_ok) begin
            check_eq({tag, "_1bit"}, 64'($countones(q ^ q_prev)), 64'd1);
        end
        prev_ok = 1'b1;
    endtask

    task automatic check_small(input string tag, input logic counted);
        check_eq({tag, "_q4"}, 64'(q4), ref_gray(64'(k4), 4));
        if (counted && prev4_ok) begin
            check_eq({tag, "_1bit4"}, 64'($countones(q4 ^ q4_prev)), 64'd1);
        end
        prev4_ok = 1'b1;
    endtask

    task automatic deposit(input logic [31:0] v);
        dut.r_bin = v;
        k32       = v;
        prev_ok   = 1'b0;
    endtask

    initial begin
        logic [31:0] wrap_exp [4];
        logic [31:0] rnd;
        n_vec    = 0;
        n_err    = 0;
        k32      = '0;
        k4       = '0;
        prev_ok  = 1'b0;
        prev4_ok = 1'b0;
        reset    = 1'b0;
        reset4   = 1'b0;
        wrap_exp = '{32'h8000_0001, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001};

        // Reset hold.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            check_eq("rst_q", 64'(q), 64'd0);
            check_eq("rst_b", 64'(dut.r_bin), 64'd0);
            check_eq("rst_q4", 64'(q4), 64'd0);
        end
        prev_ok = 1'b0;

        // Release and count 50 edges; first edge gives q = 1.
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 1'b0);
            check_main("count", 1'b1);
            if (i == 0)  check_eq("first_q", 64'(q), 64'h1);
            if (i == 15) check_eq("k16_q", 64'(q), 64'h18);
        end

        // Mid-count reset at k = 8 (q = 0xC).
        tick(1'b0, 1'b0);
        prev_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0);
            check_main("pre_mid", 1'b1);
        end
        check_eq("mid_at8", 64'(q), 64'hC);
        tick(1'b0, 1'b0);
        check_eq("mid_rst", 64'(q), 64'd0);
        prev_ok = 1'b0;
        tick(1'b1, 1'b0);
        check_eq("mid_r1", 64'(q), 64'h1);
        check_main("mid_r1", 1'b1);
        tick(1'b1, 1'b0);
        check_eq("mid_r3", 64'(q), 64'h3);
        check_main("mid_r3", 1'b1);

        // Wrap-around through 2^32-1.
        deposit(32'hFFFF_FFFD);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            check_eq("wrap_lit", 64'(q), 64'(wrap_exp[i]));
            check_main("wrap", 1'b1);
        end

        // Randomized: occasional resets and random backdoor jumps, otherwise counting.
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom_range(0, 15);
            if (rnd == 0) begin
                tick(1'b0, 1'b0);
                check_main("rnd_rst", 1'b0);
                prev_ok = 1'b0;
            end else begin
                if (rnd == 1) deposit($urandom);
                else if (rnd == 2) deposit(32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
                tick(1'b1, 1'b0);
                check_main("rnd", 1'b1);
            end
        end

        // WIDTH = 4 sweep: wraps after 0x8 back to 0x0 at edge 16.
        tick(1'b1, 1'b0);
        check_main("sw_pre", 1'b1);
        check_eq("sw_rst4", 64'(q4), 64'd0);
        prev4_ok = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b1);
            check_main("sw_main", 1'b1);
            check_small("sweep", 1'b1);
            if (i == 15) check_eq("sw_e15", 64'(q4), 64'h8);
            if (i == 16) check_eq("sw_e16", 64'(q4), 64'h0);
            if (i == 17) check_eq("sw_e17", 64'(q4), 64'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_counter32.md
Name: gray_counter32

Overview:
- Free-running synchronous Gray-code counter, WIDTH bits wide (32 by default).
- Advances one Gray code word on every clock edge.
- Output is registered, so exactly one bit of q toggles per clock, including at wrap-around.
- Used as a low-switching-activity counter for power comparison against a plain binary counter of the same width.

Parameters:
- WIDTH, 32, counter and output width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-low reset; sampled only at posedge clk.
- q  output  WIDTH  current count in reflected binary Gray code; driven directly from a register, no combinational path from any input.

Behaviour:
- State:
  - binary count register b[WIDTH-1:0].
  - output register q[WIDTH-1:0].
  - Invariant at every clock edge: q == b ^ (b >> 1).
- Reset: at a posedge clk with reset == 0, b <= 0 and q <= 0. Reset has priority; no increment occurs in that cycle.
- Count: at a posedge clk with reset == 1:
  - b <= b + 1, modulo 2^WIDTH.
  - q <= gray(b + 1), computed from the next binary value so that q and b update in the same edge.
- Latency:
  - First edge with reset high gives q = 1.
  - k edges after reset release, q = gray(k mod 2^WIDTH).
- Sequence from reset: 0, 1, 3, 2, 6, 7, 5, 4, C, D, F, E, A, B, 9, 8, 18, ... (hex).
- Single-bit change: between any two consecutive non-reset edges, popcount(q_old ^ q_new) == 1.
- Wrap:
  - b = 2^WIDTH-1 corresponds to q = 1 << (WIDTH-1), i.e. 0x80000000 for WIDTH=32.
  - The next edge gives b = 0 and q = 0. This is still a single-bit change.
  - No terminal-count flag and no saturation.
- Reset mid-count: any edge with reset == 0 forces b = 0 and q = 0 regardless of the current value. Counting resumes from 1 on the first edge with reset == 1.
- Power-up: q is undefined (X in simulation) until the first reset edge. No initial values are relied on.
- The counter has no enable input and never holds its value while reset is high.

Decomposition:
- Shared package gray_pkg:
  - constant GRAY_DEFAULT_WIDTH = 32.
  - function bin2gray(b) = b ^ (b >> 1).
  - function gray2bin(g), a prefix XOR from the MSB down; used by verification and by any future Gray decoder.
- One sub-module, gray_encode:
  - Combinational, WIDTH-parameterised bin-to-Gray converter.
  - Instantiated once on the next-state binary value b + 1.
- gray_counter32 holds both registers, the incrementer and the reset mux.

Test Plan:
- Reset hold: drive reset = 0 for 3 edges -> q == 0 after each edge; b == 0.
- Release and count: reset = 1 for 50 edges -> q follows 1, 3, 2, 6, 7, 5, 4, C, D, F, E, A, B, 9, 8, 18, ...; at edge k, gray2bin(q) == k.
- Single-bit invariant: over 50 consecutive edges, plus a sequence through the wrap -> popcount(q_prev ^ q) == 1 on every edge.
- Wrap-around: force b to 0xFFFFFFFD via a hierarchical deposit or a bench-only backdoor, then clock. The required q sequence is:
  - gray(0xFFFFFFFE) = 0x80000001
  - gray(0xFFFFFFFF) = 0x80000000
  - 0x00000000
  - 0x00000001
- Mid-count reset: count to q = 0x0000000C (k = 8), drive reset = 0 for 1 edge -> q == 0. Release -> next edges give q = 1, then 3.
- Parameter sweep: WIDTH = 4, run 20 edges -> q wraps after 0x8 back to 0x0 at edge 16; single-bit invariant holds throughout.
